// File: rtl/i_mem_prog_pkg.sv
// i_mem_pkg: shared types and default sizes for the instruction memory.
// The DATA_W/ADDR_W defaults are also used by the core's fetch stage so the
// PC width and the memory depth always agree.
package i_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic {
        ST_CLEAR = 1'b0,  // sweeping zeros through the array, one word per cycle
        ST_RUN   = 1'b1   // normal fetch and host load
    } state_t;

endpackage

// File: rtl/i_mem_prog_dp_bram.sv
// dp_bram: simple dual-port RAM with one write port and one registered read
// port. Read-first on a same-address collision. The array has no reset so
// it maps onto block RAM; only the output register can be forced to zero.
// Ports:
//   clk              clock
//   we, wa, wd       write enable / address / data
//   rd_en            update the output register from mem[ra]
//   rd_zero          synchronously force the output register to zero (wins)
//   ra               read address
//   rd               registered read data
module dp_bram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Non-blocking read of the array gives the old word on a collision.
    always_ff @(posedge clk) begin
        if (rd_zero) begin
            rd_reg <= '0;
        end else if (rd_en) begin
            rd_reg <= mem[ra];
        end
    end

    assign rd = rd_reg;

endmodule

// File: rtl/i_mem_prog.sv
// i_mem_prog: host-loadable instruction memory.
// After reset (or on clr_req) a clear engine zeroes every word, one per cycle,
// then the memory serves fetches and accepts host writes through an
// auto-incrementing write pointer.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   rd_en, rd_addr, rd_data        fetch port, 1-cycle latency, holds on stall
//   wr_addr_set, wr_addr           load the write pointer (or override it for
//                                  the current write)
//   wr_valid, wr_data, wr_ready    host write handshake
//   wr_ptr                         current write pointer
//   clr_req, busy                  clear request / clear in progress
module i_mem_prog
    import i_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_addr_set,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] wr_ptr,
    input  logic              clr_req,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] addr_eff;
    logic              fire;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [DATA_W-1:0] ram_wd;

    assign busy     = (state_reg == ST_CLEAR);
    assign wr_ready = (state_reg == ST_RUN) && !clr_req;
    assign fire     = wr_valid && wr_ready;
    assign addr_eff = wr_addr_set ? wr_addr : wr_ptr_reg;
    assign wr_ptr   = wr_ptr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            wr_ptr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        ram_we       = 1'b0;
        ram_wa       = addr_eff;
        ram_wd       = wr_data;
        case (state_reg)
            ST_CLEAR: begin
                ram_we       = 1'b1;
                ram_wa       = clr_ptr_reg;
                ram_wd       = '0;
                clr_ptr_next = clr_ptr_reg + 1'b1;
                // All-ones pointer is the last word of the array.
                if (&clr_ptr_reg) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                if (clr_req) begin
                    // Clear has priority; any pending write/pointer load is dropped.
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end else if (fire) begin
                    ram_we      = 1'b1;
                    wr_ptr_next = addr_eff + 1'b1;  // wraps modulo DEPTH
                end else if (wr_addr_set) begin
                    wr_ptr_next = wr_addr;
                end
            end
        endcase
        // No array writes while reset is held; the clear restarts at 0 anyway.
        if (!rst_n) begin
            ram_we = 1'b0;
        end
    end

    dp_bram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wa      (ram_wa),
        .wd      (ram_wd),
        .rd_en   ((state_reg == ST_RUN) && rd_en),
        .rd_zero (!rst_n || (state_reg == ST_CLEAR)),
        .ra      (rd_addr),
        .rd      (rd_data)
    );

endmodule

// File: tb/tb_i_mem_prog.sv
module tb_i_mem_prog;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_addr_set;
    logic [AW-1:0] wr_addr;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] wr_ptr;
    logic          clr_req;
    logic          busy;

    int total_checks  = 0;
    int passed_checks = 0;

    i_mem_prog dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_addr_set (wr_addr_set),
        .wr_addr     (wr_addr),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_ptr      (wr_ptr),
        .clr_req     (clr_req),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            passed_checks++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // The memory is either clearing (clear_left words still to zero, in
    // ascending order) or running. Everything else follows from the rules.
    int            clear_left = DEPTH;
    int            m_wp       = 0;
    logic [DW-1:0] m_rd       = '0;
    logic [DW-1:0] m_mem [DEPTH];
    logic          model_live = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            clear_left = DEPTH;
            m_wp       = 0;
            m_rd       = '0;
            model_live = 1'b1;
        end else if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = '0;
            clear_left--;
            m_rd = '0;
        end else begin
            if (rd_en) m_rd = m_mem[rd_addr];  // read before write: old word
            if (clr_req) begin
                clear_left = DEPTH;
            end else if (wr_valid) begin
                int a;
                a        = wr_addr_set ? int'(wr_addr) : m_wp;
                m_mem[a] = wr_data;
                m_wp     = (a + 1) % DEPTH;
            end else if (wr_addr_set) begin
                m_wp = int'(wr_addr);
            end
        end
    end

    // One compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("busy",     {31'b0, busy},     {31'b0, clear_left > 0});
            check("wr_ready", {31'b0, wr_ready}, {31'b0, (clear_left == 0) && !clr_req});
            check("wr_ptr",   {23'b0, wr_ptr},   m_wp[DW-1:0]);
            check("rd_data",  rd_data,           m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic read_word(input int a);
        rd_en   = 1'b1;
        rd_addr = a[AW-1:0];
        step();
    endtask

    task automatic write_word(input logic set, input int a, input logic [DW-1:0] d);
        wr_addr_set = set;
        wr_addr     = a[AW-1:0];
        wr_valid    = 1'b1;
        wr_data     = d;
        step();
        wr_addr_set = 1'b0;
        wr_valid    = 1'b0;
    endtask

    initial begin
        int n;
        logic accepted;

        rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_addr_set = 1'b0;
        wr_addr = '0; wr_valid = 1'b0; wr_data = '0; clr_req = 1'b0;
        step(); step(); step();

        // Reset values
        check("rst_busy",     {31'b0, busy},     32'd1);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        check("rst_rd_data",  rd_data,           32'd0);
        check("rst_wr_ptr",   {23'b0, wr_ptr},   32'd0);

        rst_n = 1'b1;
        wait_idle(n);
        check("clear_len_reset", n, 32'd512);
        check("ready_after_clear", {31'b0, wr_ready}, 32'd1);
        read_word(0);   check("rd0_zero",   rd_data, 32'd0);
        read_word(255); check("rd255_zero", rd_data, 32'd0);
        read_word(511); check("rd511_zero", rd_data, 32'd0);

        // Load sequence
        write_word(1'b1, 0, 32'h0000_0202);
        write_word(1'b0, 0, 32'h0000_0203);
        write_word(1'b0, 0, 32'h0000_0498);
        check("load_wr_ptr", {23'b0, wr_ptr}, 32'd3);
        read_word(0); check("load_rd0", rd_data, 32'h0000_0202);
        read_word(1); check("load_rd1", rd_data, 32'h0000_0203);
        read_word(2); check("load_rd2", rd_data, 32'h0000_0498);

        // Pointer load, wrap, stall
        wr_addr_set = 1'b1; wr_addr = 9'd511; step(); wr_addr_set = 1'b0;
        check("ptr_set_511", {23'b0, wr_ptr}, 32'd511);
        write_word(1'b0, 0, 32'hAAAA_0001);
        write_word(1'b0, 0, 32'hAAAA_0002);
        check("wrap_wr_ptr", {23'b0, wr_ptr}, 32'd1);
        read_word(511); check("wrap_rd511", rd_data, 32'hAAAA_0001);
        read_word(0);   check("wrap_rd0",   rd_data, 32'hAAAA_0002);
        rd_en = 1'b0; rd_addr = 9'd1; step(); step();
        check("stall_hold", rd_data, 32'hAAAA_0002);

        // Collision: read-first
        rd_en = 1'b1; rd_addr = 9'd5;
        write_word(1'b1, 5, 32'h1234_5678);
        check("collide_old", rd_data, 32'd0);
        read_word(5); check("collide_new", rd_data, 32'h1234_5678);

        // Randomized traffic; host holds a word until it is accepted
        wr_valid = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            accepted = wr_valid && wr_ready;
            if (accepted || !wr_valid) begin
                wr_valid    = ($urandom_range(0, 2) != 0);
                wr_addr_set = ($urandom_range(0, 7) == 0);
                wr_addr     = AW'($urandom);
                wr_data     = $urandom;
            end
            rd_en   = ($urandom_range(0, 3) != 0);
            rd_addr = AW'($urandom_range(0, 15));
            clr_req = (c == 700);
            step();
        end
        wr_valid = 1'b0; wr_addr_set = 1'b0; clr_req = 1'b0;
        wait_idle(n);

        // Clear request together with a write: write dropped, full clear
        write_word(1'b1, 5, 32'h1234_5678);
        n = int'(wr_ptr);
        wr_addr_set = 1'b1; wr_addr = 9'd7; wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0; wr_valid = 1'b0; wr_addr_set = 1'b0;
        check("clr_ptr_kept", {23'b0, wr_ptr}, 32'd6);
        wait_idle(n);
        check("clear_len_req", n, 32'd512);
        for (int a = 0; a < DEPTH; a++) read_word(a);
        read_word(5); check("cleared_rd5", rd_data, 32'd0);
        read_word(7); check("cleared_rd7", rd_data, 32'd0);

        // Reset at clear cycle 100 restarts the full clear
        clr_req = 1'b1; step(); clr_req = 1'b0;
        for (int i = 0; i < 100; i++) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        wait_idle(n);
        check("clear_len_restart", n, 32'd512);
        step();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
